// File: rtl/stack_datapath_if.sv
// Command/result bundle between the stack-machine control unit (master) and the datapath (slave).
// The control unit drives strobes and operands; the datapath returns top-of-stack, ALU result and status.
interface stack_datapath_if #(
    parameter int DATA_RANGE  = 8,
    parameter int STACK_DEPTH = 16,
    parameter int FLAGS_COUNT = 2
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

    logic [DATA_RANGE-1:0]  datapath_in;
    logic                   cache_a_b_not;
    logic                   cache_en;
    logic                   ALUOP;
    logic                   push_result;
    logic                   push_alu;
    logic                   is_data_indirect;
    logic                   pop_operand;
    logic                   write_mem_result;
    logic [DATA_RANGE-1:0]  data_memory_write_addr;

    logic [DATA_RANGE-1:0]  stack_out;
    logic [DATA_RANGE-1:0]  alu_out;
    logic [FLAGS_COUNT-1:0] flags;
    logic [DEPTH_W-1:0]     depth;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output datapath_in, cache_a_b_not, cache_en, ALUOP, push_result, push_alu,
               is_data_indirect, pop_operand, write_mem_result, data_memory_write_addr,
        input  stack_out, alu_out, flags, depth, overflow, underflow
    );

    modport slave (
        input  datapath_in, cache_a_b_not, cache_en, ALUOP, push_result, push_alu,
               is_data_indirect, pop_operand, write_mem_result, data_memory_write_addr,
        output stack_out, alu_out, flags, depth, overflow, underflow
    );
endinterface

// File: rtl/stack_datapath.sv
// Operand stack, A/B cache, 8-bit add/sub ALU, flags and data memory; stack updates land 1 cycle after the strobe.
// No backpressure: every strobe is acted on; rejected pushes/pops only set the sticky overflow/underflow flags.
module stack_datapath #(
    parameter int DATA_RANGE  = 8,
    parameter int STACK_DEPTH = 16,
    parameter int FLAGS_COUNT = 2
) (
    input  logic              clk,
    input  logic              rst,
    stack_datapath_if.slave   bus
);
    localparam int PTR_W   = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = PTR_W + 1;
    localparam int DMEM_N  = 2 ** DATA_RANGE;

    logic [DATA_RANGE-1:0]  stack_mem [STACK_DEPTH];
    logic [DATA_RANGE-1:0]  dmem      [DMEM_N];

    logic [DEPTH_W-1:0]     sp;
    logic [DATA_RANGE-1:0]  a_reg;
    logic [DATA_RANGE-1:0]  b_reg;
    logic [FLAGS_COUNT-1:0] flags_reg;
    logic                   overflow_reg;
    logic                   underflow_reg;

    logic                   empty;
    logic                   full;
    logic [PTR_W-1:0]       top_idx;
    logic [DATA_RANGE-1:0]  top_val;
    logic [DATA_RANGE-1:0]  alu_val;
    logic [DATA_RANGE-1:0]  push_val;

    logic                   stk_wr_en;
    logic [PTR_W-1:0]       stk_wr_idx;
    logic [DEPTH_W-1:0]     sp_nxt;
    logic                   ovf_set;
    logic                   udf_set;
    logic                   push_taken;

    assign empty   = (sp == '0);
    assign full    = (sp == DEPTH_W'(STACK_DEPTH));
    // When full, the low pointer bits wrap to 0, so minus one still lands on the last entry.
    assign top_idx = sp[PTR_W-1:0] - 1'b1;
    assign top_val = empty ? '0 : stack_mem[top_idx];

    assign alu_val = bus.ALUOP ? (a_reg - b_reg) : (a_reg + b_reg);

    always_comb begin
        push_val = bus.datapath_in;
        if (bus.push_alu) begin
            push_val = alu_val;
        end else if (bus.is_data_indirect) begin
            push_val = dmem[bus.datapath_in];
        end
    end

    // Stack command decode; push+pop on a non-empty stack is an in-place replace of the top.
    always_comb begin
        stk_wr_en  = 1'b0;
        stk_wr_idx = sp[PTR_W-1:0];
        sp_nxt     = sp;
        ovf_set    = 1'b0;
        udf_set    = 1'b0;
        push_taken = 1'b0;
        if (bus.push_result && !bus.pop_operand) begin
            if (full) begin
                ovf_set = 1'b1;
            end else begin
                stk_wr_en  = 1'b1;
                push_taken = 1'b1;
                sp_nxt     = sp + 1'b1;
            end
        end else if (bus.pop_operand && !bus.push_result) begin
            if (empty) begin
                udf_set = 1'b1;
            end else begin
                sp_nxt = sp - 1'b1;
            end
        end else if (bus.push_result && bus.pop_operand) begin
            stk_wr_en  = 1'b1;
            push_taken = 1'b1;
            if (empty) begin
                sp_nxt = sp + 1'b1;
            end else begin
                stk_wr_idx = top_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp            <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            flags_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            sp <= sp_nxt;
            if (bus.cache_en) begin
                if (bus.cache_a_b_not) begin
                    a_reg <= bus.datapath_in;
                end else begin
                    b_reg <= bus.datapath_in;
                end
            end
            if (push_taken && bus.push_alu) begin
                flags_reg <= {push_val[DATA_RANGE-1], (push_val == '0)};
            end
            if (ovf_set) begin
                overflow_reg <= 1'b1;
            end
            if (udf_set) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    // Storage arrays carry no reset; writes are simply suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && stk_wr_en) begin
            stack_mem[stk_wr_idx] <= push_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bus.write_mem_result) begin
            dmem[bus.data_memory_write_addr] <= top_val;
        end
    end

    assign bus.stack_out = top_val;
    assign bus.alu_out   = alu_val;
    assign bus.flags     = flags_reg;
    assign bus.depth     = sp;
    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;

endmodule
